// File: rtl/dir_input_queue.sv
`timescale 1ns/1ps
// dir_input_queue: debounced four-way direction buttons feeding a 2-deep move queue committed on game ticks.
// Optional feature macro DIR_INPUT_QUEUE_SEED_EN: a free-running LFSR is folded into seed_out on every accepted push.
module dir_input_queue #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int DEBOUNCE_W = 18
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        btn_up_n,
  input  logic        btn_down_n,
  input  logic        btn_left,
  input  logic        btn_right,
  input  logic        tick,
  output logic [1:0]  dir_out,
  output logic        dir_changed,
  output logic [1:0]  queue_count,
  output logic [15:0] seed_out
);
  localparam logic [3:0] RELEASED_RAW = 4'b0011;
  localparam logic [DEBOUNCE_W-1:0] DB_LAST = DEBOUNCE_W'(DEBOUNCE_CYCLES - 1);

  logic                  rst_n;
  logic [3:0]            raw, sync1, sync2, pressed, stable, differ, settle, rise;
  logic [DEBOUNCE_W-1:0] cnt [4];
  logic [1:0]            q0, q1, q0_n, q1_n, ev_dir, ref_dir, base;
  logic                  ev_any, accept, pop, push;

  assign raw = {btn_right, btn_left, btn_down_n, btn_up_n};
  assign pressed = sync2 ^ RELEASED_RAW;

  // internal reset: asserts at once, releases on the first clk after deassertion
  always_ff @(posedge clk or negedge reset)
    if (!reset) rst_n <= 1'b0;
    else rst_n <= 1'b1;

  // two-flop synchronizers, idling at each button's released level
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sync1 <= RELEASED_RAW;
      sync2 <= RELEASED_RAW;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end

  // a button settles on the last of DEBOUNCE_CYCLES disagreeing cycles; settling high is a press
  always_comb begin
    differ = pressed ^ stable;
    settle = '0;
    for (int i = 0; i < 4; i++) settle[i] = differ[i] && (cnt[i] == DB_LAST);
    rise = settle & pressed;
  end

  // debounce counters run only while the synchronized level disagrees with the stable one
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      stable <= '0;
      for (int i = 0; i < 4; i++) cnt[i] <= '0;
    end else begin
      stable <= stable ^ settle;
      for (int i = 0; i < 4; i++) cnt[i] <= (differ[i] && !settle[i]) ? cnt[i] + DEBOUNCE_W'(1) : '0;
    end

  // priority pick, check against the pre-cycle tail, and next FIFO contents
  always_comb begin
    ev_any = |rise;
    ev_dir = rise[0] ? 2'd0 : rise[1] ? 2'd1 : rise[2] ? 2'd2 : 2'd3;
    ref_dir = (queue_count == 2'd0) ? dir_out : (queue_count == 2'd1) ? q0 : q1;
    accept = ev_any && (ev_dir[1] != ref_dir[1]);
    pop = tick && (queue_count != 2'd0);
    push = accept && ((queue_count != 2'd2) || pop);
    base = queue_count - {1'b0, pop};
    q0_n = (push && base == 2'd0) ? ev_dir : pop ? q1 : q0;
    q1_n = (push && base == 2'd1) ? ev_dir : q1;
  end

  // commit the head on a tick and advance the queue
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      dir_out <= 2'd0;
      dir_changed <= 1'b0;
      queue_count <= 2'd0;
      q0 <= 2'd0;
      q1 <= 2'd0;
    end else begin
      dir_out <= pop ? q0 : dir_out;
      dir_changed <= pop;
      queue_count <= base + {1'b0, push};
      q0 <= q0_n;
      q1 <= q1_n;
    end

`ifdef DIR_INPUT_QUEUE_SEED_EN
  logic [15:0] lfsr;

  // Fibonacci LFSR x^16+x^14+x^13+x^11, mixed into the seed whenever a push lands
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      lfsr <= 16'hACE1;
      seed_out <= 16'h0;
    end else begin
      lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      seed_out <= push ? seed_out ^ lfsr : seed_out;
    end
`else
  assign seed_out = 16'h0;
`endif
endmodule

// File: tb/tb_dir_input_queue.sv
`timescale 1ns/1ps
// tb_dir_input_queue: directed and random button actions checked against a queue-based move model
module tb_dir_input_queue;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        btn_up_n = 1'b1;
  logic        btn_down_n = 1'b1;
  logic        btn_left = 1'b0;
  logic        btn_right = 1'b0;
  logic        tick = 1'b0;
  logic [1:0]  dir_out;
  logic        dir_changed;
  logic [1:0]  queue_count;
  logic [15:0] seed_out;

  int checks = 0;
  int failures = 0;
  int pulses = 0;
  int exp_pulses = 0;
  int mdir = 0;
  int mq[$];

  dir_input_queue #(.DEBOUNCE_CYCLES(4), .DEBOUNCE_W(3)) dut (
    .clk(clk),
    .reset(reset),
    .btn_up_n(btn_up_n),
    .btn_down_n(btn_down_n),
    .btn_left(btn_left),
    .btn_right(btn_right),
    .tick(tick),
    .dir_out(dir_out),
    .dir_changed(dir_changed),
    .queue_count(queue_count),
    .seed_out(seed_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    if (dir_changed === 1'b1) pulses++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic set_btn(input logic [3:0] m);
    btn_up_n = ~m[0];
    btn_down_n = ~m[1];
    btn_left = m[2];
    btn_right = m[3];
  endtask

  task automatic verify(input string tag);
    chk({tag, ":count"}, 32'(queue_count), 32'(mq.size()));
    chk({tag, ":dir"}, 32'(dir_out), 32'(mdir));
    chk({tag, ":changed"}, 32'(dir_changed), 32'd0);
    chk({tag, ":pulses"}, 32'(pulses), 32'(exp_pulses));
`ifndef DIR_INPUT_QUEUE_SEED_EN
    chk({tag, ":seed"}, 32'(seed_out), 32'd0);
`endif
  endtask

  task automatic model_event(input logic [3:0] m, input bit with_tick);
    int d, r;
    d = m[0] ? 0 : m[1] ? 1 : m[2] ? 2 : 3;
    r = (mq.size() > 0) ? mq[$] : mdir;
    if (with_tick && mq.size() > 0) begin
      mdir = mq.pop_front();
      exp_pulses++;
    end
    if ((d / 2) != (r / 2) && mq.size() < 2) mq.push_back(d);
  endtask

  task automatic press(input logic [3:0] m, input bit with_tick, input string tag);
    set_btn(m);
    repeat (5) @(negedge clk);
    tick = with_tick;
    @(negedge clk);
    tick = 1'b0;
    repeat (4) @(negedge clk);
    set_btn(4'b0);
    repeat (10) @(negedge clk);
    model_event(m, with_tick);
    verify(tag);
  endtask

  task automatic do_tick(input string tag);
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    repeat (3) @(negedge clk);
    if (mq.size() > 0) begin
      mdir = mq.pop_front();
      exp_pulses++;
    end
    verify(tag);
  endtask

  task automatic glitch(input int b, input int len, input string tag);
    set_btn(4'(1 << b));
    repeat (len) @(negedge clk);
    set_btn(4'b0);
    repeat (10) @(negedge clk);
    verify(tag);
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b0;
    #1;
    mq.delete();
    mdir = 0;
    verify({tag, ":asserted"});
    repeat (3) @(negedge clk);
    verify({tag, ":held"});
    reset = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    verify("reset");
    reset = 1'b1;
    repeat (3) @(negedge clk);
    verify("reset_release");

    press(4'b1000, 1'b0, "right_press");
`ifdef DIR_INPUT_QUEUE_SEED_EN
    chk("seed_nonzero", 32'(seed_out != 16'h0), 32'd1);
`endif
    do_tick("right_tick");

    press(4'b0100, 1'b0, "left_opposite");
    do_tick("empty_tick");

    press(4'b0001, 1'b0, "pending_up");
    set_btn(4'b0001);
    repeat (3) @(negedge clk);
    set_btn(4'b0);
    do_reset("mid_reset");
    repeat (12) @(negedge clk);
    verify("after_mid_reset");

    set_btn(4'b0100);
    do_reset("held_reset");
    repeat (12) @(negedge clk);
    model_event(4'b0100, 1'b0);
    verify("held_press");
    set_btn(4'b0);
    repeat (10) @(negedge clk);
    do_reset("clean_reset");

    press(4'b0100, 1'b0, "seq_left");
    press(4'b1000, 1'b0, "seq_right");
    press(4'b0001, 1'b0, "seq_up");
    press(4'b0010, 1'b0, "seq_down");
    do_tick("seq_tick1");
    do_tick("seq_tick2");

    glitch(0, 3, "glitch_up");

    press(4'b0100, 1'b0, "fill_left");
    press(4'b0010, 1'b0, "fill_down");
    press(4'b1000, 1'b1, "full_tick_push");
    press(4'b0001, 1'b0, "full_drop");
    do_tick("drain1");
    do_tick("drain2");

    press(4'b1110, 1'b0, "multi_press");
    do_tick("multi_tick");

    for (int k = 0; k < 40; k++) begin
      case ($urandom_range(0, 3))
        0: press(4'($urandom_range(1, 15)), 1'b0, $sformatf("rnd%0d_press", k));
        1: press(4'($urandom_range(1, 15)), 1'b1, $sformatf("rnd%0d_ptick", k));
        2: do_tick($sformatf("rnd%0d_tick", k));
        default: glitch(int'($urandom_range(0, 3)), int'($urandom_range(1, 3)), $sformatf("rnd%0d_glitch", k));
      endcase
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/dir_input_queue.md
DIR_INPUT_QUEUE -- requirements
Module: dir_input_queue

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 250000, meaning consecutive stable clk cycles required to accept a button level change.
REQ-002 SHALL have parameter DEBOUNCE_W, default 18, meaning debounce counter width; DEBOUNCE_CYCLES SHALL fit in DEBOUNCE_W bits.
REQ-003 clk  input  1  system clock; all state on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 btn_up_n  input  1  up button, asynchronous, active-low (pressed = 0).
REQ-006 btn_down_n  input  1  down button, asynchronous, active-low.
REQ-007 btn_left  input  1  left button, asynchronous, active-high (pressed = 1).
REQ-008 btn_right  input  1  right button, asynchronous, active-high.
REQ-009 tick  input  1  game-step strobe, one clk wide, from the game stage.
REQ-010 dir_out  output  2  committed direction: 0 up, 1 down, 2 left, 3 right.
REQ-011 dir_changed  output  1  one-cycle pulse when dir_out takes a new value.
REQ-012 queue_count  output  2  pending direction entries, 0..2.
REQ-013 seed_out  output  16  random seed captured on accepted presses.

Function
REQ-014 Each button SHALL pass a 2-flop synchronizer, then be normalized to active-high "pressed".
REQ-015 Debounce per button: stable level SHALL change only after the synchronized level differs from it for DEBOUNCE_CYCLES consecutive cycles; any agreeing cycle clears that button's counter.
REQ-016 Press event SHALL be a 0->1 transition of the debounced level; releases generate nothing.
REQ-017 Multiple press events in one cycle: only the highest priority (up > down > left > right) SHALL be considered; others dropped.
REQ-018 Reference direction = queue tail if queue_count > 0, else dir_out, sampled from pre-cycle state.
REQ-019 Event SHALL be accepted only if direction != reference and direction != opposite(reference) (up/down, left/right); otherwise dropped.
REQ-020 Queue: 2-entry FIFO; accepted event pushed at tail; push when full and no simultaneous pop SHALL be dropped with no state change.
REQ-021 On tick with queue_count > 0: dir_out <= head one cycle later, entry popped, dir_changed = 1 for that cycle.
REQ-022 On tick with empty queue: dir_out unchanged, dir_changed = 0.
REQ-023 Tick and accepted push in same cycle: both occur; full queue with tick SHALL accept the push; count = old - 1 + 1.
REQ-024 Empty queue, tick and push same cycle: push lands in queue, dir_out unchanged that tick.
REQ-025 Latency: button change to press event = 2 + DEBOUNCE_CYCLES cycles (±1); press to queue_count update = 1 cycle.
REQ-026 queue_count SHALL never exceed 2 or wrap.

Reset
REQ-027 Reset assertion SHALL immediately force: dir_out = 0, dir_changed = 0, queue_count = 0, seed_out = 0, debounced levels = released, debounce counters = 0, synchronizers = released.
REQ-028 Reset mid-debounce or with pending entries SHALL discard them; buttons held through reset release SHALL be treated as new presses after debounce.
REQ-029 Reset deassertion SHALL be synchronized to clk internally; first functional edge is the second clk after deassertion.

Configuration
REQ-030 Macro DIR_INPUT_QUEUE_SEED_EN defined: 16-bit Fibonacci LFSR (taps 16,14,13,11), reset value 16'hACE1, advances every cycle; on each accepted push seed_out <= seed_out ^ LFSR.
REQ-031 DIR_INPUT_QUEUE_SEED_EN undefined: no LFSR, seed_out constant 0.

Verification (DEBOUNCE_CYCLES = 4 for bench)
REQ-032 Reset, press btn_right 10 cycles, tick -> queue_count 1 then 0, dir_out = 3, one dir_changed pulse.
REQ-033 dir_out = 3, press left then tick -> press dropped, queue_count 0, dir_out stays 3, no pulse.
REQ-034 dir_out = 0, press left, right, up, down in order, no tick -> queue holds {2,0}? no: left accepted, right dropped (opposite), up accepted, down dropped; queue_count = 2; two ticks -> dir_out 2 then 0.
REQ-035 Glitch: btn_up_n low for 3 cycles -> no event, queue_count stays 0.
REQ-036 Queue full {2,1}, tick and left-reversal-safe press (up from tail 1 invalid; use right) same cycle -> dir_out = 2, queue {1,3}, queue_count 2.
REQ-037 With DIR_INPUT_QUEUE_SEED_EN, first accepted press N cycles after reset -> seed_out = LFSR value at that cycle (nonzero); without macro -> seed_out = 0 throughout.
